// File: rtl/data_memory_dump.sv
// Word-addressed data memory with a ready/valid dump port that streams its contents.
// Processor writes are accepted only while no dump is in progress.
module data_memory_dump #(
  parameter int unsigned N         = 64,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned SKIP_ZERO = 0
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         memWrite,
  input  logic [N-1:0] address,
  input  logic [N-1:0] writeData,
  output logic [N-1:0] readData,
  input  logic         dump,
  output logic         dump_valid,
  input  logic         dump_ready,
  output logic [N-1:0] dump_addr,
  output logic [N-1:0] dump_data,
  output logic         dump_busy,
  output logic         dump_done,
  output logic         wr_dropped
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          SKIP = (SKIP_ZERO != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [N-1:0]  mem_q [DEPTH];
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] p_q, p_d;
  logic          dump_q;
  logic          wr_dropped_q;

  logic [AW-1:0] idx;
  logic          in_range;
  logic          dump_start;
  logic [N-1:0]  mem_p;
  logic          p_zero;
  logic          advance;
  logic          unused_addr_bits;

  assign idx              = address[AW+2:3];
  assign unused_addr_bits = ^address[2:0];

  // Any set bit above the word-index field means the access misses the memory.
  generate
    if (N > AW + 3) begin : g_hi_bits
      assign in_range = (address[N-1:AW+3] == '0);
    end else begin : g_no_hi_bits
      assign in_range = 1'b1;
    end
  endgenerate

  assign readData   = in_range ? mem_q[idx] : '0;
  assign dump_start = dump && !dump_q;
  assign mem_p      = mem_q[p_q];
  assign p_zero     = (mem_p == '0);
  assign dump_busy  = (state_q == S_RUN) || (state_q == S_DONE);
  assign dump_done  = (state_q == S_DONE);
  assign wr_dropped = wr_dropped_q;

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    dump_valid = 1'b0;
    dump_data  = '0;
    dump_addr  = '0;
    advance    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dump_start) begin
          state_d = S_RUN;
          p_d     = '0;
        end
      end
      S_RUN: begin
        dump_valid = !SKIP || !p_zero;
        if (dump_valid) begin
          dump_data = mem_p;
          dump_addr = N'({p_q, 3'b000});
        end
        // Zero words are stepped over one per cycle without presenting a beat.
        advance = (dump_valid && dump_ready) || (SKIP && p_zero);
        if (advance) begin
          if (p_q == AW'(DEPTH - 1)) begin
            state_d = S_DONE;
          end else begin
            p_d = p_q + AW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= S_IDLE;
      p_q          <= '0;
      dump_q       <= 1'b0;
      wr_dropped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      dump_q  <= dump;
      if (memWrite && (state_q != S_IDLE)) begin
        wr_dropped_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (memWrite && in_range && (state_q == S_IDLE)) begin
      mem_q[idx] <= writeData;
    end
  end

endmodule

// File: tb/tb_data_memory_dump.sv
// Directed bench: one plain dump instance and one zero-skipping instance, both DEPTH=8.
module tb_data_memory_dump;

  localparam int unsigned N = 64;
  localparam int unsigned D = 8;

  logic         clk;
  logic         reset;
  logic         memWrite;
  logic [N-1:0] address;
  logic [N-1:0] writeData;
  logic         dump0, dump1;
  logic         dump_ready;

  logic [N-1:0] rd0, rd1, addr0, addr1, data0, data1;
  logic         valid0, valid1, busy0, busy1, done0, done1, drop0, drop1;

  int checks;
  int errors;

  data_memory_dump #(.N(N), .DEPTH(D), .SKIP_ZERO(0)) dut0 (
    .CLOCK_50(clk), .reset(reset), .memWrite(memWrite), .address(address),
    .writeData(writeData), .readData(rd0), .dump(dump0), .dump_valid(valid0),
    .dump_ready(dump_ready), .dump_addr(addr0), .dump_data(data0),
    .dump_busy(busy0), .dump_done(done0), .wr_dropped(drop0)
  );

  data_memory_dump #(.N(N), .DEPTH(D), .SKIP_ZERO(1)) dut1 (
    .CLOCK_50(clk), .reset(reset), .memWrite(memWrite), .address(address),
    .writeData(writeData), .readData(rd1), .dump(dump1), .dump_valid(valid1),
    .dump_ready(dump_ready), .dump_addr(addr1), .dump_data(data1),
    .dump_busy(busy1), .dump_done(done1), .wr_dropped(drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] pat(input int k);
    return 64'h0101_0000_0000_0000 | 64'(k + 1);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic wr(input logic [N-1:0] a, input logic [N-1:0] d);
    memWrite  = 1'b1;
    address   = a;
    writeData = d;
    step();
    memWrite = 1'b0;
    #1;
  endtask

  task automatic pulse_dump0;
    dump0 = 1'b1;
    step();
    dump0 = 1'b0;
    #1;
  endtask

  task automatic pulse_dump1;
    dump1 = 1'b1;
    step();
    dump1 = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    address = 64'h0;
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done0); end
    checks++; if (drop0 !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", drop0); end
    checks++; if (rd0 !== 64'h0) begin errors++; $display("FAIL reset_mem got %h want 0", rd0); end
    checks++; if (addr0 !== 64'h0 || data0 !== 64'h0) begin errors++; $display("FAIL reset_beat got %h/%h want 0/0", addr0, data0); end
  endtask

  task automatic test_rw;
    do_reset();
    memWrite = 1'b1; address = 64'h10; writeData = 64'hA5;
    #1;
    checks++; if (rd0 !== 64'h0) begin errors++; $display("FAIL rw_same_cycle got %h want 0", rd0); end
    step();
    memWrite = 1'b0;
    #1;
    checks++; if (rd0 !== 64'hA5) begin errors++; $display("FAIL rw_0x10 got %h want a5", rd0); end
    address = 64'h13; #1;
    checks++; if (rd0 !== 64'hA5) begin errors++; $display("FAIL rw_0x13 got %h want a5", rd0); end
    address = 64'h18; #1;
    checks++; if (rd0 !== 64'h0) begin errors++; $display("FAIL rw_0x18 got %h want 0", rd0); end
    wr(64'h50, 64'hFF);
    address = 64'h50; #1;
    checks++; if (rd0 !== 64'h0) begin errors++; $display("FAIL rw_oor_read got %h want 0", rd0); end
    address = 64'h10; #1;
    checks++; if (rd0 !== 64'hA5) begin errors++; $display("FAIL rw_oor_alias got %h want a5", rd0); end
    wr(64'h38, 64'h77);
    address = 64'h38; #1;
    checks++; if (rd0 !== 64'h77) begin errors++; $display("FAIL rw_last_word got %h want 77", rd0); end
  endtask

  task automatic test_dump;
    do_reset();
    for (int k = 0; k < int'(D); k++) wr(64'(k * 8), pat(k));
    pulse_dump0();
    dump_ready = 1'b1;
    #1;
    for (int k = 0; k < int'(D); k++) begin
      checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL dump_valid beat %0d got %b want 1", k, valid0); end
      checks++; if (addr0 !== 64'(k * 8)) begin errors++; $display("FAIL dump_addr beat %0d got %h want %h", k, addr0, 64'(k * 8)); end
      checks++; if (data0 !== pat(k)) begin errors++; $display("FAIL dump_data beat %0d got %h want %h", k, data0, pat(k)); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL dump_early_done beat %0d got %b want 0", k, done0); end
      step();
    end
    checks++; if (done0 !== 1'b1 || busy0 !== 1'b1) begin errors++; $display("FAIL dump_done got done=%b busy=%b want 1/1", done0, busy0); end
    checks++; if (valid0 !== 1'b0 || addr0 !== 64'h0 || data0 !== 64'h0) begin errors++; $display("FAIL dump_done_beat got v=%b %h/%h want 0 0/0", valid0, addr0, data0); end
    step();
    checks++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL dump_idle got done=%b busy=%b want 0/0", done0, busy0); end
  endtask

  task automatic test_stall;
    int  k;
    int  stalled;
    bit  seen_done;
    k = 0; stalled = 0; seen_done = 1'b0;
    pulse_dump0();
    for (int c = 0; c < 40; c++) begin
      dump_ready = !(k == 2 && stalled < 3);
      dump0      = (k == 2 && stalled == 1);
      #1;
      if (done0) begin
        seen_done = 1'b1;
        break;
      end
      checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL stall_valid cycle %0d got %b want 1", c, valid0); end
      checks++; if (addr0 !== 64'(k * 8) || data0 !== pat(k)) begin errors++; $display("FAIL stall_beat %0d got %h/%h want %h/%h", k, addr0, data0, 64'(k * 8), pat(k)); end
      if (dump_ready) k++;
      else stalled++;
      step();
    end
    dump0 = 1'b0;
    dump_ready = 1'b1;
    checks++; if (!seen_done) begin errors++; $display("FAIL stall_timeout got no done want done"); end
    checks++; if (k != int'(D)) begin errors++; $display("FAIL stall_beat_count got %0d want %0d", k, D); end
    checks++; if (stalled != 3) begin errors++; $display("FAIL stall_cycles got %0d want 3", stalled); end
    step();
    step();
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL stall_no_restart got busy=%b want 0", busy0); end
  endtask

  task automatic test_skip_zero;
    logic exp_v;
    do_reset();
    wr(64'h08, 64'h11);
    wr(64'h28, 64'h55);
    pulse_dump1();
    dump_ready = 1'b1;
    #1;
    for (int c = 0; c < int'(D); c++) begin
      exp_v = (c == 1 || c == 5);
      checks++; if (valid1 !== exp_v) begin errors++; $display("FAIL skip_valid cycle %0d got %b want %b", c, valid1, exp_v); end
      if (exp_v) begin
        checks++; if (addr1 !== 64'(c * 8) || data1 !== ((c == 1) ? 64'h11 : 64'h55)) begin errors++; $display("FAIL skip_beat cycle %0d got %h/%h", c, addr1, data1); end
      end else begin
        checks++; if (addr1 !== 64'h0 || data1 !== 64'h0) begin errors++; $display("FAIL skip_idle_beat cycle %0d got %h/%h want 0/0", c, addr1, data1); end
      end
      step();
    end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL skip_done got %b want 1", done1); end
    step();
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL skip_idle got busy=%b done=%b want 0/0", busy1, done1); end
  endtask

  task automatic test_skip_all_zero;
    do_reset();
    pulse_dump1();
    for (int c = 0; c < int'(D); c++) begin
      checks++; if (valid1 !== 1'b0 || busy1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL allzero cycle %0d got v=%b busy=%b done=%b want 0/1/0", c, valid1, busy1, done1); end
      step();
    end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL allzero_done got %b want 1", done1); end
    step();
  endtask

  task automatic test_wr_drop;
    bit seen_done;
    seen_done = 1'b0;
    do_reset();
    wr(64'h08, 64'h11);
    pulse_dump0();
    dump_ready = 1'b0;
    memWrite = 1'b1; address = 64'h08; writeData = 64'hBAD;
    step();
    memWrite = 1'b0;
    dump_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (done0) begin
        seen_done = 1'b1;
        break;
      end
      step();
    end
    checks++; if (!seen_done) begin errors++; $display("FAIL drop_timeout got no done want done"); end
    step();
    step();
    address = 64'h08; #1;
    checks++; if (drop0 !== 1'b1) begin errors++; $display("FAIL drop_flag got %b want 1", drop0); end
    checks++; if (rd0 !== 64'h11) begin errors++; $display("FAIL drop_mem got %h want 11", rd0); end
    checks++; if (drop1 !== 1'b0 || rd1 !== 64'hBAD) begin errors++; $display("FAIL drop_idle_write got flag=%b rd=%h want 0/bad", drop1, rd1); end
    do_reset();
    checks++; if (drop0 !== 1'b0) begin errors++; $display("FAIL drop_cleared got %b want 0", drop0); end
  endtask

  task automatic test_reset_mid_dump;
    bit seen_done;
    seen_done = 1'b0;
    do_reset();
    for (int k = 0; k < int'(D); k++) wr(64'(k * 8), pat(k));
    pulse_dump0();
    dump_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) step();
    checks++; if (valid0 !== 1'b1 || addr0 !== 64'h18) begin errors++; $display("FAIL mid_beat3 got v=%b addr=%h want 1/18", valid0, addr0); end
    reset = 1'b1; memWrite = 1'b1; address = 64'h0; writeData = 64'h99; dump0 = 1'b1;
    step();
    reset = 1'b0; memWrite = 1'b0; dump0 = 1'b0;
    #1;
    checks++; if (valid0 !== 1'b0 || done0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL mid_abort got v=%b done=%b busy=%b want 0/0/0", valid0, done0, busy0); end
    checks++; if (rd0 !== 64'h0) begin errors++; $display("FAIL mid_write_blocked got %h want 0", rd0); end
    address = 64'h18; #1;
    checks++; if (rd0 !== 64'h0) begin errors++; $display("FAIL mid_mem_clear got %h want 0", rd0); end
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL mid_quiet cycle %0d got done=%b busy=%b want 0/0", c, done0, busy0); end
    end
    pulse_dump0();
    checks++; if (valid0 !== 1'b1 || addr0 !== 64'h0 || data0 !== 64'h0) begin errors++; $display("FAIL mid_restart got v=%b %h/%h want 1 0/0", valid0, addr0, data0); end
    for (int c = 0; c < 20; c++) begin
      #1;
      if (done0) begin
        seen_done = 1'b1;
        break;
      end
      step();
    end
    checks++; if (!seen_done) begin errors++; $display("FAIL mid_restart_timeout got no done want done"); end
    step();
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; memWrite = 1'b0; address = '0; writeData = '0;
    dump0 = 1'b0; dump1 = 1'b0; dump_ready = 1'b0;
    test_reset();
    test_rw();
    test_dump();
    test_stall();
    test_skip_zero();
    test_skip_all_zero();
    test_wr_drop();
    test_reset_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_dump.md
DATA_MEMORY_DUMP -- requirements
Module: data_memory_dump

Interface
REQ-001 Parameter: N, default 64, data/address width in bits.
REQ-002 Parameter: DEPTH, default 64, number of N-bit words; power of two, 2..1024.
REQ-003 Parameter: SKIP_ZERO, default 0, when 1 the dump omits words equal to zero.
REQ-004 Port: CLOCK_50  input  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: memWrite  input  1  write enable from processor.
REQ-007 Port: address  input  N  byte address from processor; word index = address[log2(DEPTH)+2:3].
REQ-008 Port: writeData  input  N  write data.
REQ-009 Port: readData  output  N  combinational read data for address.
REQ-010 Port: dump  input  1  dump request; rising edge starts a dump.
REQ-011 Port: dump_valid  output  1  dump beat present.
REQ-012 Port: dump_ready  input  1  consumer accepts beat.
REQ-013 Port: dump_addr  output  N  byte address of current beat (index*8).
REQ-014 Port: dump_data  output  N  word of current beat.
REQ-015 Port: dump_busy  output  1  high in RUN and DONE states.
REQ-016 Port: dump_done  output  1  one-cycle pulse at dump completion.
REQ-017 Port: wr_dropped  output  1  sticky flag: a write was ignored during a dump.

Function
REQ-018 Memory: DEPTH words of N bits; address[2:0] ignored (no misalignment fault).
REQ-019 Address with bits above the index field nonzero is out of range: write ignored, readData = 0.
REQ-020 readData combinational, zero added latency; write on rising edge when memWrite=1, state IDLE, address in range.
REQ-021 Read of a word written in the same cycle returns the old value until the edge.
REQ-022 FSM states IDLE, RUN, DONE; dump_start = dump high and dump registered-low previous cycle.
REQ-023 IDLE -> RUN on dump_start; pointer p cleared to 0 on that edge.
REQ-024 In RUN: dump_valid = (SKIP_ZERO==0) or mem[p]!=0; dump_data = mem[p]; dump_addr = p*8.
REQ-025 In RUN, p advances on dump_valid && dump_ready, or when SKIP_ZERO skips a zero word (one word per cycle, no beat).
REQ-026 dump_valid, dump_data, dump_addr stay stable while dump_valid && !dump_ready.
REQ-027 When p = DEPTH-1 advances, RUN -> DONE; p does not wrap within a dump.
REQ-028 DONE: dump_done = 1 for exactly one cycle, then -> IDLE.
REQ-029 dump_start while RUN or DONE is ignored; a new dump requires a fresh rising edge in IDLE.
REQ-030 memWrite=1 in RUN or DONE: memory unchanged, wr_dropped set to 1 and held until reset.
REQ-031 Outputs dump_valid, dump_done, dump_busy are 0 in IDLE; dump_addr, dump_data = 0 when dump_valid=0.
REQ-032 SKIP_ZERO=1 with all-zero memory: RUN lasts DEPTH cycles, no beats, then dump_done.

Reset
REQ-033 reset=1 on a rising edge: state IDLE, p = 0, all memory words = 0, wr_dropped = 0, registered dump = 0.
REQ-034 Reset mid-dump aborts immediately: no dump_done pulse, dump_valid = 0 the following cycle.
REQ-035 Reset has priority over memWrite and dump_start in the same cycle.

Verification
REQ-036 Write 0xA5 to address 0x10, read address 0x10 and 0x13 -> readData = 0xA5 both; address 0x18 -> 0.
REQ-037 SKIP_ZERO=0, DEPTH=8, dump pulse, dump_ready=1 -> 8 beats on consecutive cycles, addr 0x00..0x38, dump_done one cycle after last beat.
REQ-038 Stall: dump_ready=0 for 3 cycles on beat 2 -> dump_data/dump_addr (0x10) held constant, no beat lost or duplicated.
REQ-039 SKIP_ZERO=1, words 1 and 5 nonzero -> exactly 2 beats, addr 0x08 then 0x28, then dump_done.
REQ-040 memWrite during dump -> memory unchanged (verified by readData after done), wr_dropped=1 until reset.
REQ-041 reset asserted at beat 3 of 8 -> dump_valid=0 next cycle, no dump_done, memory reads 0, new dump starts from address 0.
